reshuffle_scheduler: RTL and testbench
======================================

# reshuffle_scheduler

Sequencing controller for the reshuffle stage between the PosT array and the output buffer. Accepts one N×N output tile per handshake from the PosT array and buffers it in a 2-entry FIFO. Generates the per-tile row-rotation `step` that drives the combinational reshuffle network, and presents tile plus step downstream with valid/ready flow control. Tracks tile position within a frame and signals frame completion.

## Interface
- `N`, 4, tile edge; power of two, ≥2
- `WIDTH`, 32, signed element width
- `CNT_W`, 16, width of tile-row / tile-column config and counters
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse; latches config, begins frame
- `abort`  in  1  synchronous clear to IDLE; discards FIFO contents
- `cfg_tiles_per_row`  in  CNT_W  tiles per tile row
- `cfg_tile_rows`  in  CNT_W  tile rows per frame
- `cfg_rot`  in  $clog2(N)  step increment per tile
- `in_valid`  in  1  PosT tile valid
- `in_ready`  out  1  scheduler can accept
- `in_patch`  in  signed WIDTH [0:N-1][0:N-1]  tile from PosT array
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  output buffer accepts
- `out_patch`  out  signed WIDTH [0:N-1][0:N-1]  head tile, to reshuffle network
- `out_step`  out  $clog2(N)  rotation step for head tile
- `out_last`  out  1  head tile is last of frame
- `busy`  out  1  state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse at end of frame
- `cfg_err`  out  1  one-cycle pulse: start with zero config
- `stat_stall_cycles`  out  32  cycles with out_valid & !out_ready

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `start` with both cfg counts nonzero latches config, clears counters, step=0, → RUN. `start` with either count zero → `cfg_err` pulse, stay IDLE.
- RUN: `in_ready` = (fifo_count < 2). Accept when `in_valid & in_ready`. Each accepted tile is pushed with the current step and a `last` tag.
- Counters: col 0..tiles_per_row-1, row 0..tile_rows-1. On accept:
  - step_next = step+cfg_rot, minus N if ≥N.
  - At col wrap, col=0, row++, and step resets to 0.
- Accepting tile at (row=tile_rows-1, col=tiles_per_row-1) tags `last=1` → DRAIN.
- DRAIN: `in_ready`=0. When FIFO is empty → DONE.
- DONE: `frame_done`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored.
- `abort` in any state: FIFO count=0, counters=0, → IDLE. No `frame_done`. `abort` has priority over same-cycle `start` and handshakes.
- FIFO: 2 entries.
  - Pop on `out_valid & out_ready`.
  - Simultaneous push and pop at count 1 keeps count 1, and the head advances to the new tile.
  - Push is never attempted at count 2 because `in_ready` is low.
- `out_patch`/`out_step`/`out_last` hold stable while `out_valid & !out_ready`.

## Timing
- Reset values:
  - state IDLE
  - `in_ready`=0, `out_valid`=0, `out_step`=0, `out_last`=0
  - `out_patch`=0
  - `busy`=0, `frame_done`=0, `cfg_err`=0, `stat_stall_cycles`=0
- Latency: tile accepted in cycle t appears on `out_*` in cycle t+1 if the FIFO was empty.
- Throughput: one tile/cycle sustained when `out_ready`=1.
- `in_ready` depends only on registered state and count. It has no combinational path from `out_ready`.
- `frame_done` is asserted the cycle after the last tile pops; `busy` drops the cycle after that.
- `stat_stall_cycles` saturates at 2^32-1 and clears on `start` acceptance.

## Configuration
- `RESHUFFLE_SCHED_STATS_EN` defined: `stat_stall_cycles` counter implemented as specified.
- Not defined: `stat_stall_cycles` is tied to 0 and no counter logic is generated. All other behaviour is identical.

## Test plan
- N=4, rot=1, 3×2 tiles, out_ready=1 → out_step sequence 0,1,2,0,1,2; out_last on 6th tile; frame_done one cycle after 6th pop.
- rot=3, tiles_per_row=5 → steps 0,3,2,1,0 (mod-4 wrap); next row restarts at 0.
- out_ready held low for 4 cycles with in_valid=1 → FIFO fills to 2, in_ready=0, out_patch/out_step stable; stat_stall_cycles=4 (macro on) or 0 (macro off).
- start with cfg_tile_rows=0 → cfg_err pulse, busy stays 0; start mid-RUN → ignored, counters unchanged.
- abort after 3 of 6 tiles with 2 tiles buffered → next cycle: IDLE, out_valid=0, no frame_done; new start runs a clean frame from step 0.
- rst_n asserted mid-DRAIN → all outputs take reset values immediately; after release, remain IDLE until start.

Source files
------------

// File: rtl/reshuffle_scheduler.sv
`default_nettype none
// reshuffle_scheduler: buffers PosT tiles in a 2-entry FIFO, tags each with its row-rotation step and frame-last flag.
// Optional macro RESHUFFLE_SCHED_STATS_EN enables the output stall-cycle counter.
module reshuffle_scheduler #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [CNT_W-1:0]                      cfg_tiles_per_row,
  input  logic [CNT_W-1:0]                      cfg_tile_rows,
  input  logic [$clog2(N)-1:0]                  cfg_rot,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [0:N-1][0:N-1][WIDTH-1:0] in_patch,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [0:N-1][0:N-1][WIDTH-1:0] out_patch,
  output logic [$clog2(N)-1:0]                  out_step,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  cfg_err,
  output logic [31:0]                           stat_stall_cycles
);

  localparam int SW = $clog2(N);
  localparam logic [SW:0] N_EXT = (SW+1)'(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] tpr, rows, col, row;
  logic [SW-1:0]    rot, step;

  logic signed [0:N-1][0:N-1][WIDTH-1:0] mem_patch [0:1];
  logic [SW-1:0]                         mem_step  [0:1];
  logic [1:0]                            mem_last;
  logic                                  rd_ptr, wr_ptr;
  logic [1:0]                            count;

  logic          push, pop, accept_start, cfg_zero, col_wrap, is_last;
  logic [SW:0]   step_sum, step_wrap;
  logic [SW-1:0] step_adv;

  assign cfg_zero     = (cfg_tiles_per_row == '0) || (cfg_tile_rows == '0);
  assign accept_start = (state == IDLE) && start && !abort && !cfg_zero;

  // in_ready is a function of registered state and count only
  assign in_ready  = (state == RUN) && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign col_wrap  = (col == tpr - CNT_W'(1));
  assign is_last   = col_wrap && (row == rows - CNT_W'(1));

  assign step_sum  = {1'b0, step} + {1'b0, rot};
  assign step_wrap = step_sum - N_EXT;
  assign step_adv  = (step_sum >= N_EXT) ? step_wrap[SW-1:0] : step_sum[SW-1:0];

  assign out_patch = mem_patch[rd_ptr];
  assign out_step  = mem_step[rd_ptr];
  assign out_last  = mem_last[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    case (state)
      IDLE:    if (accept_start) state_next = RUN;
      RUN:     if (push && is_last) state_next = DRAIN;
      // leave DRAIN as soon as the final entry pops so frame_done follows the pop by one cycle
      DRAIN:   if ((count == 2'd0) || ((count == 2'd1) && pop)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_patch[i] <= '0;
        mem_step[i]  <= '0;
      end
      mem_last <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (abort) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem_patch[wr_ptr] <= in_patch;
        mem_step[wr_ptr]  <= step;
        mem_last[wr_ptr]  <= is_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tpr  <= '0;
      rows <= '0;
      rot  <= '0;
      col  <= '0;
      row  <= '0;
      step <= '0;
    end else if (abort) begin
      col  <= '0;
      row  <= '0;
      step <= '0;
    end else if (accept_start) begin
      tpr  <= cfg_tiles_per_row;
      rows <= cfg_tile_rows;
      rot  <= cfg_rot;
      col  <= '0;
      row  <= '0;
      step <= '0;
    end else if (push) begin
      if (col_wrap) begin
        col  <= '0;
        row  <= row + CNT_W'(1);
        step <= '0;
      end else begin
        col  <= col + CNT_W'(1);
        step <= step_adv;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && start && !abort && cfg_zero;
    end
  end

`ifdef RESHUFFLE_SCHED_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (accept_start) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_stall_cycles = stall_q;
`else
  assign stat_stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reshuffle_scheduler.sv
`default_nettype none
// Scoreboard bench for reshuffle_scheduler: a tile-index reference model predicts step/last and
// flow-control outputs; randomized valid/ready plus directed abort, cfg error and reset cases.
module tb_reshuffle_scheduler;

  localparam int N     = 4;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;
  localparam int SW    = $clog2(N);

  typedef logic signed [0:N-1][0:N-1][WIDTH-1:0] patch_t;
  typedef struct {
    patch_t patch;
    int     step;
    bit     last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] cfg_tiles_per_row = '0;
  logic [CNT_W-1:0] cfg_tile_rows = '0;
  logic [SW-1:0]    cfg_rot = '0;
  patch_t           in_patch = '0;
  patch_t           out_patch;
  logic             in_ready, out_valid, out_last, busy, frame_done, cfg_err;
  logic [SW-1:0]    out_step;
  logic [31:0]      stat_stall_cycles;

  int     n_cmp = 0;
  int     n_bad = 0;
  exp_t   q[$];
  int     ph = 0;          // 0 idle, 1 accepting, 2 draining, 3 done
  int     mk = 0;          // tiles accepted this frame
  int     m_tpr = 1, m_rows = 1, m_rot = 0;
  bit     exp_err = 1'b0;
  longint exp_stall = 0;

  always #5 clk = ~clk;

  reshuffle_scheduler #(.N(N), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .abort             (abort),
    .cfg_tiles_per_row (cfg_tiles_per_row),
    .cfg_tile_rows     (cfg_tile_rows),
    .cfg_rot           (cfg_rot),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_patch          (in_patch),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_patch         (out_patch),
    .out_step          (out_step),
    .out_last          (out_last),
    .busy              (busy),
    .frame_done        (frame_done),
    .cfg_err           (cfg_err),
    .stat_stall_cycles (stat_stall_cycles)
  );

  task automatic chk(input string nm, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, want, $time);
    end
  endtask

  task automatic chk_head(input exp_t e);
    n_cmp++;
    if (out_patch !== e.patch || int'(out_step) != e.step || out_last !== e.last) begin
      n_bad++;
      $display("FAIL head: got step=%0d last=%0d patch=%h, expected step=%0d last=%0d patch=%h at %0t",
               out_step, out_last, out_patch, e.step, e.last, e.patch, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_stall"}, stat_stall_cycles, 0);
    chk({tag, "_out_step"}, out_step, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_patch_zero"}, (out_patch == '0), 1);
  endtask

  function automatic patch_t rand_patch();
    patch_t p;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        p[i][j] = $urandom();
    return p;
  endfunction

  // Monitor and reference model: compares what the DUT presents this cycle, then advances
  // the model across the coming rising edge using the (stable) inputs.
  always @(negedge clk) begin
    int   qsz;
    bit   hs_in, hs_out, zero;
    exp_t e;
    if (!rst_n) begin
      check_reset_outputs("rst");
      q.delete();
      ph = 0; mk = 0; exp_err = 1'b0; exp_stall = 0;
    end else begin
      qsz = q.size();
      chk("in_ready", in_ready, (ph == 1 && qsz < 2));
      chk("out_valid", out_valid, (qsz != 0));
      chk("busy", busy, (ph != 0));
      chk("frame_done", frame_done, (ph == 3));
      chk("cfg_err", cfg_err, exp_err);
`ifdef RESHUFFLE_SCHED_STATS_EN
      chk("stall_cycles", stat_stall_cycles, exp_stall);
`else
      chk("stall_cycles", stat_stall_cycles, 0);
`endif
      if (qsz != 0 && out_valid) chk_head(q[0]);

      hs_in   = in_valid && (ph == 1) && (qsz < 2);
      hs_out  = out_ready && (qsz != 0);
      zero    = (cfg_tiles_per_row == 0) || (cfg_tile_rows == 0);
      exp_err = (ph == 0) && start && !abort && zero;
      if (ph == 0 && start && !abort && !zero) exp_stall = 0;
      else if (qsz != 0 && !out_ready) exp_stall++;

      if (abort) begin
        q.delete();
        ph = 0;
        mk = 0;
      end else begin
        case (ph)
          0: if (start && !zero) begin
               m_tpr  = int'(cfg_tiles_per_row);
               m_rows = int'(cfg_tile_rows);
               m_rot  = int'(cfg_rot);
               mk     = 0;
               ph     = 1;
             end
          1, 2: begin
            if (hs_out) void'(q.pop_front());
            if (hs_in) begin
              e.patch = in_patch;
              e.step  = ((mk % m_tpr) * m_rot) % N;
              e.last  = (mk == m_tpr * m_rows - 1);
              q.push_back(e);
              mk++;
              if (e.last) ph = 2;
            end else if (ph == 2 && q.size() == 0) begin
              ph = 3;
            end
          end
          3: ph = 0;
          default: ph = 0;
        endcase
      end
    end
  end

  task automatic pulse_start(input int tpr, input int rows, input int rot);
    @(posedge clk); #1;
    cfg_tiles_per_row = CNT_W'(tpr);
    cfg_tile_rows     = CNT_W'(rows);
    cfg_rot           = SW'(rot);
    start             = 1'b1;
    in_valid          = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // hold: leading cycles with in_valid=1/out_ready=0; restart: cycle to pulse a stray start
  task automatic run_frame(input int tpr, input int rows, input int rot,
                           input int vp, input int rp, input int hold, input int restart);
    int cyc = 0;
    pulse_start(tpr, rows, rot);
    while (ph != 0 && cyc < 3000) begin
      in_valid  = (cyc < hold) ? 1'b1 : ($urandom_range(0, 99) < vp);
      out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) < rp);
      in_patch  = rand_patch();
      start     = (cyc == restart);
      if (cyc == restart) begin
        cfg_tiles_per_row = CNT_W'(1);
        cfg_tile_rows     = CNT_W'(1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (ph != 0) begin
      n_bad++;
      $display("FAIL frame_timeout: model phase %0d after %0d cycles, expected idle", ph, cyc);
    end
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(3, 2, 1, 100, 100, 0, -1);
    run_frame(5, 2, 3, 70, 60, 0, -1);
    run_frame(4, 2, 2, 100, 100, 5, -1);

    // zero config: cfg_err pulse, stays idle
    @(posedge clk); #1;
    cfg_tiles_per_row = CNT_W'(3); cfg_tile_rows = CNT_W'(0); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    cfg_tiles_per_row = CNT_W'(0); cfg_tile_rows = CNT_W'(2); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);

    run_frame(3, 2, 1, 80, 80, 0, 2);

    // abort with three tiles accepted and two buffered
    pulse_start(3, 2, 1);
    cyc = 0;
    while (!(mk == 3 && q.size() == 2) && cyc < 20) begin
      in_valid  = 1'b1;
      in_patch  = rand_patch();
      out_ready = (mk == 2 && q.size() == 2);
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (!(mk == 3 && q.size() == 2)) begin
      n_bad++;
      $display("FAIL abort_setup: accepted %0d buffered %0d, expected 3 and 2", mk, q.size());
    end
    abort = 1'b1; in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    run_frame(3, 2, 1, 100, 100, 0, -1);

    // asynchronous reset while draining
    pulse_start(2, 1, 2);
    cyc = 0;
    while (ph != 2 && cyc < 20) begin
      in_valid = 1'b1; out_ready = 1'b0; in_patch = rand_patch();
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (ph != 2) begin
      n_bad++;
      $display("FAIL drain_setup: model phase %0d, expected 2", ph);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    for (int f = 0; f < 6; f++) begin
      run_frame($urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(0, N-1),
                $urandom_range(40, 100), $urandom_range(30, 100), 0, -1);
    end
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
